// File: rtl/data_mem_ctrl.sv
// Single-port data memory sequencer for LOAD, STORE and word-by-word COPY; one request at a time.
// LOAD 3 cycles, STORE 2, reserved 1, COPY 3N+1 from accept to rsp_valid; req_ready only in IDLE, nothing is queued.
module data_mem_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_dst,
  input  logic [3:0] req_len,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       D_rd,
  output logic       D_wr,
  output logic [3:0] D_addr,
  output logic [3:0] W_data,
  input  logic [3:0] R_data
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, CP_RD, CP_WAIT, CP_WR, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] src_q, src_d;
  logic [3:0] dst_q, dst_d;
  logic [3:0] wdata_q, wdata_d;
  logic [3:0] buf_q, buf_d;
  logic [3:0] rdata_q, rdata_d;
  logic [4:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       accept;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = req_addr;
          dst_d   = req_dst;
          wdata_d = req_wdata;
          // A zero length encodes a full 16-word copy.
          cnt_d   = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
          err_d   = (req_op == 2'b11);
          case (req_op)
            2'b00:   state_d = RD;
            2'b01:   state_d = WR;
            2'b10:   state_d = CP_RD;
            default: state_d = DONE;
          endcase
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = R_data;
        state_d = DONE;
      end
      WR:      state_d = DONE;
      CP_RD:   state_d = CP_WAIT;
      CP_WAIT: begin
        buf_d   = R_data;
        rdata_d = R_data;
        state_d = CP_WR;
      end
      CP_WR: begin
        src_d   = src_q + 4'd1;
        dst_d   = dst_q + 4'd1;
        cnt_d   = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? DONE : CP_RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write data stay zero whenever no strobe is active.
  always_comb begin
    req_ready = (state_q == IDLE) && !reset;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    rsp_err   = (state_q == DONE) && err_q;
    rsp_data  = rdata_q;
    D_rd      = 1'b0;
    D_wr      = 1'b0;
    D_addr    = 4'd0;
    W_data    = 4'd0;
    case (state_q)
      RD, CP_RD: begin
        D_rd   = 1'b1;
        D_addr = src_q;
      end
      WR: begin
        D_wr   = 1'b1;
        D_addr = src_q;
        W_data = wdata_q;
      end
      CP_WR: begin
        D_wr   = 1'b1;
        D_addr = dst_q;
        W_data = buf_q;
      end
      default: ;
    endcase
  end

endmodule
